// File: rtl/servant_bus_sched.sv
// Three-master to one-slave Wishbone scheduler: m0 fixed priority, m1/m2 round-robin.
// Grant registered one cycle after request; ack forwarded same cycle; forced ack after TIMEOUT wait cycles.
module servant_bus_sched #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_m0_adr,
  input  logic [31:0] i_m0_dat,
  input  logic [3:0]  i_m0_sel,
  input  logic        i_m0_we,
  input  logic        i_m0_cyc,
  output logic [31:0] o_m0_rdt,
  output logic        o_m0_ack,
  input  logic [31:0] i_m1_adr,
  input  logic [31:0] i_m1_dat,
  input  logic [3:0]  i_m1_sel,
  input  logic        i_m1_we,
  input  logic        i_m1_cyc,
  output logic [31:0] o_m1_rdt,
  output logic        o_m1_ack,
  input  logic [31:0] i_m2_adr,
  input  logic        i_m2_cyc,
  output logic [31:0] o_m2_rdt,
  output logic        o_m2_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rr_q, rr_d;   // 0: m1 wins a tie with m2, 1: m2 wins

  logic g_cyc, act, live, fire_to, done;

  always_comb begin
    g_cyc = 1'b0;
    case (grant_q)
      2'd0:    g_cyc = i_m0_cyc;
      2'd1:    g_cyc = i_m1_cyc;
      2'd2:    g_cyc = i_m2_cyc;
      default: g_cyc = 1'b0;
    endcase

    act     = (state_q == BUSY) && !i_rst;
    live    = act && g_cyc;
    // A slave ack landing on the last wait cycle takes precedence over the forced completion.
    fire_to = live && !i_wb_ack && (cnt_q == WAIT_LAST);
    done    = live && (i_wb_ack || fire_to);

    o_wb_adr  = 32'h0;
    o_wb_dat  = 32'h0;
    o_wb_sel  = 4'h0;
    o_wb_we   = 1'b0;
    o_wb_cyc  = live;
    o_grant   = act ? grant_q : 2'd3;
    o_timeout = fire_to;
    if (act) begin
      case (grant_q)
        2'd0: begin
          o_wb_adr = i_m0_adr; o_wb_dat = i_m0_dat; o_wb_sel = i_m0_sel; o_wb_we = i_m0_we;
        end
        2'd1: begin
          o_wb_adr = i_m1_adr; o_wb_dat = i_m1_dat; o_wb_sel = i_m1_sel; o_wb_we = i_m1_we;
        end
        2'd2: begin
          o_wb_adr = i_m2_adr; o_wb_sel = 4'hF;
        end
        default: ;
      endcase
    end

    o_m0_rdt = fire_to ? 32'h0 : i_wb_rdt;
    o_m1_rdt = o_m0_rdt;
    o_m2_rdt = o_m0_rdt;
    o_m0_ack = done && (grant_q == 2'd0);
    o_m1_ack = done && (grant_q == 2'd1);
    o_m2_ack = done && (grant_q == 2'd2);

    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (i_m0_cyc || i_m1_cyc || i_m2_cyc) begin
          state_d = BUSY;
          cnt_d   = 16'h0;
          if (i_m0_cyc)                  grant_d = 2'd0;
          else if (i_m1_cyc && i_m2_cyc) grant_d = rr_q ? 2'd2 : 2'd1;
          else if (i_m1_cyc)             grant_d = 2'd1;
          else                           grant_d = 2'd2;
        end
      end
      BUSY: begin
        if (!g_cyc || done) begin
          state_d = IDLE;
          grant_d = 2'd3;
          if (done && grant_q == 2'd1) rr_d = 1'b1;
          if (done && grant_q == 2'd2) rr_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= 2'd3;
      cnt_q   <= 16'h0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_servant_bus_sched.sv
// Directed bench for servant_bus_sched with TIMEOUT=4.
module tb_servant_bus_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m0_adr = '0, m0_dat = '0, m1_adr = '0, m1_dat = '0, m2_adr = '0;
  logic [3:0]  m0_sel = '0, m1_sel = '0;
  logic        m0_we = 1'b0, m0_cyc = 1'b0, m1_we = 1'b0, m1_cyc = 1'b0, m2_cyc = 1'b0;
  logic [31:0] m0_rdt, m1_rdt, m2_rdt;
  logic        m0_ack, m1_ack, m2_ack;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc;
  logic [31:0] wb_rdt = '0;
  logic        wb_ack = 1'b0;
  logic [1:0]  grant;
  logic        tmo;

  int checks = 0;
  int errors = 0;
  logic [1:0] g_exp [8] = '{2'd1, 2'd3, 2'd2, 2'd3, 2'd1, 2'd3, 2'd2, 2'd3};

  servant_bus_sched #(.TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_adr(m0_adr), .i_m0_dat(m0_dat), .i_m0_sel(m0_sel), .i_m0_we(m0_we), .i_m0_cyc(m0_cyc),
    .o_m0_rdt(m0_rdt), .o_m0_ack(m0_ack),
    .i_m1_adr(m1_adr), .i_m1_dat(m1_dat), .i_m1_sel(m1_sel), .i_m1_we(m1_we), .i_m1_cyc(m1_cyc),
    .o_m1_rdt(m1_rdt), .o_m1_ack(m1_ack),
    .i_m2_adr(m2_adr), .i_m2_cyc(m2_cyc), .o_m2_rdt(m2_rdt), .o_m2_ack(m2_ack),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel), .o_wb_we(wb_we), .o_wb_cyc(wb_cyc),
    .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack), .o_grant(grant), .o_timeout(tmo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_grant", {30'h0, grant}, 32'd3);
    chk("rst_cyc", {31'h0, wb_cyc}, 32'd0);
    chk("rst_we", {31'h0, wb_we}, 32'd0);
    chk("rst_acks", {29'h0, m0_ack, m1_ack, m2_ack}, 32'd0);
    chk("rst_tmo", {31'h0, tmo}, 32'd0);
    rst = 1'b0;

    // m1 write, slave acks on the third busy cycle
    m1_cyc = 1'b1; m1_we = 1'b1; m1_adr = 32'h100; m1_dat = 32'hDEADBEEF; m1_sel = 4'hF;
    #1;
    chk("w_first_seen_cyc", {31'h0, wb_cyc}, 32'd0);
    chk("w_first_seen_grant", {30'h0, grant}, 32'd3);
    tick();
    chk("w_cyc", {31'h0, wb_cyc}, 32'd1);
    chk("w_adr", wb_adr, 32'h100);
    chk("w_dat", wb_dat, 32'hDEADBEEF);
    chk("w_sel", {28'h0, wb_sel}, 32'hF);
    chk("w_we", {31'h0, wb_we}, 32'd1);
    chk("w_grant", {30'h0, grant}, 32'd1);
    chk("w_noack1", {31'h0, m1_ack}, 32'd0);
    tick();
    chk("w_grant2", {30'h0, grant}, 32'd1);
    chk("w_noack2", {31'h0, m1_ack}, 32'd0);
    tick();
    wb_ack = 1'b1; #1;
    chk("w_ack", {31'h0, m1_ack}, 32'd1);
    chk("w_other_acks", {30'h0, m0_ack, m2_ack}, 32'd0);
    chk("w_tmo", {31'h0, tmo}, 32'd0);
    tick();
    wb_ack = 1'b0; m1_cyc = 1'b0; m1_we = 1'b0; #1;
    chk("w_idle_grant", {30'h0, grant}, 32'd3);
    chk("w_idle_cyc", {31'h0, wb_cyc}, 32'd0);
    chk("w_idle_ack", {31'h0, m1_ack}, 32'd0);

    // m1/m2 round-robin from a fresh reset; ack held high is ignored while idle
    rst = 1'b1; tick(); rst = 1'b0;
    m1_cyc = 1'b1; m2_cyc = 1'b1; wb_ack = 1'b1; #1;
    chk("rr_idle_ack_ignored", {30'h0, m1_ack, m2_ack}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rr_grant_%0d", k), {30'h0, grant}, {30'h0, g_exp[k]});
      chk($sformatf("rr_m1ack_%0d", k), {31'h0, m1_ack}, {31'h0, g_exp[k] == 2'd1});
      chk($sformatf("rr_m2ack_%0d", k), {31'h0, m2_ack}, {31'h0, g_exp[k] == 2'd2});
    end
    m1_cyc = 1'b0; m2_cyc = 1'b0;

    // all three at once: m0, then m1, then m2
    m0_cyc = 1'b1; m1_cyc = 1'b1; m2_cyc = 1'b1;
    tick();
    chk("pri_g0", {30'h0, grant}, 32'd0);
    chk("pri_ack0", {29'h0, m0_ack, m1_ack, m2_ack}, 32'b100);
    tick(); m0_cyc = 1'b0; #1;
    chk("pri_idle0", {30'h0, grant}, 32'd3);
    tick();
    chk("pri_g1", {30'h0, grant}, 32'd1);
    chk("pri_ack1", {29'h0, m0_ack, m1_ack, m2_ack}, 32'b010);
    tick(); m1_cyc = 1'b0; #1;
    chk("pri_idle1", {30'h0, grant}, 32'd3);
    tick();
    chk("pri_g2", {30'h0, grant}, 32'd2);
    chk("pri_ack2", {29'h0, m0_ack, m1_ack, m2_ack}, 32'b001);
    tick(); m2_cyc = 1'b0; wb_ack = 1'b0; #1;
    chk("pri_idle2", {30'h0, grant}, 32'd3);

    // m2 read, slave silent: forced completion on the 4th busy cycle
    m2_cyc = 1'b1; m2_adr = 32'h200; wb_rdt = 32'hAAAA5555;
    tick();
    chk("to_grant", {30'h0, grant}, 32'd2);
    chk("to_adr", wb_adr, 32'h200);
    chk("to_we", {31'h0, wb_we}, 32'd0);
    chk("to_sel", {28'h0, wb_sel}, 32'hF);
    chk("to_dat", wb_dat, 32'h0);
    chk("to_tmo1", {31'h0, tmo}, 32'd0);
    tick();
    chk("to_tmo2", {31'h0, tmo}, 32'd0);
    tick();
    chk("to_tmo3", {31'h0, tmo}, 32'd0);
    chk("to_ack3", {31'h0, m2_ack}, 32'd0);
    tick();
    chk("to_tmo4", {31'h0, tmo}, 32'd1);
    chk("to_ack4", {31'h0, m2_ack}, 32'd1);
    chk("to_rdt4", m2_rdt, 32'h0);
    tick(); m2_cyc = 1'b0; #1;
    chk("to_idle_grant", {30'h0, grant}, 32'd3);
    chk("to_idle_cyc", {31'h0, wb_cyc}, 32'd0);
    chk("to_idle_tmo", {31'h0, tmo}, 32'd0);

    // ack arriving in the timeout cycle wins
    m1_cyc = 1'b1; m1_we = 1'b0; m1_adr = 32'h300;
    tick(); tick(); tick(); tick();
    wb_ack = 1'b1; wb_rdt = 32'h12345678; #1;
    chk("race_ack", {31'h0, m1_ack}, 32'd1);
    chk("race_rdt", m1_rdt, 32'h12345678);
    chk("race_tmo", {31'h0, tmo}, 32'd0);
    tick(); m1_cyc = 1'b0; wb_ack = 1'b0; #1;
    chk("race_idle", {30'h0, grant}, 32'd3);

    // reset mid-transfer, then an abort of a fresh transfer
    m1_cyc = 1'b1; m1_we = 1'b1;
    tick();
    chk("rab_grant", {30'h0, grant}, 32'd1);
    tick(); rst = 1'b1; wb_ack = 1'b1; #1;
    chk("rab_rst_acks", {29'h0, m0_ack, m1_ack, m2_ack}, 32'd0);
    tick(); rst = 1'b0; wb_ack = 1'b0; #1;
    chk("rab_rst_grant", {30'h0, grant}, 32'd3);
    chk("rab_rst_cyc", {31'h0, wb_cyc}, 32'd0);
    tick();
    chk("rab_fresh_grant", {30'h0, grant}, 32'd1);
    m1_cyc = 1'b0; #1;
    chk("rab_abort_cyc", {31'h0, wb_cyc}, 32'd0);
    chk("rab_abort_ack", {31'h0, m1_ack}, 32'd0);
    tick();
    chk("rab_abort_grant", {30'h0, grant}, 32'd3);
    chk("rab_abort_tmo", {31'h0, tmo}, 32'd0);
    chk("rab_abort_ack2", {29'h0, m0_ack, m1_ack, m2_ack}, 32'd0);

    // the abort must not have moved the round-robin pointer off m1
    m1_cyc = 1'b1; m2_cyc = 1'b1; m1_we = 1'b0;
    tick();
    chk("rab_rr_grant", {30'h0, grant}, 32'd1);
    wb_ack = 1'b1; #1;
    chk("rab_rr_ack", {31'h0, m1_ack}, 32'd1);
    tick(); m1_cyc = 1'b0; m2_cyc = 1'b0; wb_ack = 1'b0; #1;
    chk("rab_end_grant", {30'h0, grant}, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/servant_bus_sched.md
SERVANT_BUS_SCHED -- requirements
Module: servant_bus_sched

Interface
REQ-001 Parameter TIMEOUT, default 255; maximum slave wait in cycles before forced completion; legal range 1..65535.
REQ-002 Port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port i_rst  input  1  reset; synchronous and active-high.
REQ-004 Ports i_m0_adr/i_m0_dat  input  32/32  debug-module master address/write data.
REQ-005 Ports i_m0_sel/i_m0_we/i_m0_cyc  input  4/1/1  debug-module master byte select, write enable, cycle request.
REQ-006 Ports o_m0_rdt/o_m0_ack  output  32/1  debug-module master read data and ack.
REQ-007 Ports i_m1_adr/i_m1_dat/i_m1_sel/i_m1_we/i_m1_cyc, o_m1_rdt/o_m1_ack  same widths as m0  CPU data-bus master.
REQ-008 Ports i_m2_adr (32), i_m2_cyc (1) input, o_m2_rdt (32), o_m2_ack (1) output  CPU instruction-bus master; read-only.
REQ-009 Ports o_wb_adr/o_wb_dat  output  32/32  shared slave address/write data.
REQ-010 Ports o_wb_sel/o_wb_we/o_wb_cyc  output  4/1/1  shared slave byte select, write enable, cycle.
REQ-011 Ports i_wb_rdt/i_wb_ack  input  32/1  shared slave read data and single-cycle ack.
REQ-012 Port o_grant  output  2  granted master index (0,1,2); 3 = none.
REQ-013 Port o_timeout  output  1  one-cycle pulse on forced completion.

Function
REQ-014 The FSM SHALL have two states: IDLE and BUSY.
REQ-015 In IDLE with any m*_cyc high, it SHALL register a grant and enter BUSY next cycle; o_wb_cyc rises one cycle after the request is first seen.
REQ-016 Priority: m0 always wins; between m1 and m2 round-robin, the CPU port served last having lower priority.
REQ-017 In BUSY, o_wb_adr/dat/sel/we SHALL follow the granted master combinationally; for m2: we=0, sel=4'hF, dat=0.
REQ-018 In IDLE, o_wb_cyc/we/adr/dat/sel SHALL be 0 and o_grant SHALL be 3.
REQ-019 In BUSY, o_wb_cyc SHALL be 1 while the granted master's cyc is 1.
REQ-020 i_wb_ack in BUSY SHALL be forwarded to the granted master's o_m*_ack in the same cycle; FSM returns to IDLE next cycle.
REQ-021 All o_m*_rdt SHALL carry i_wb_rdt; only the granted master's ack may assert; at most one o_m*_ack high per cycle.
REQ-022 A wait counter SHALL clear on BUSY entry and increment each BUSY cycle without i_wb_ack.
REQ-023 When the counter reaches TIMEOUT without ack: granted master gets ack with rdt 32'h0, o_timeout pulses 1 cycle, o_wb_cyc drops, FSM goes IDLE.
REQ-024 i_wb_ack in the same cycle as timeout SHALL win: normal ack with i_wb_rdt, no o_timeout.
REQ-025 If the granted master drops cyc in BUSY without ack (abort), FSM SHALL return to IDLE next cycle with no ack and no o_timeout; o_wb_cyc goes 0 that same cycle.
REQ-026 The round-robin pointer SHALL update only on completion (ack or timeout) of an m1/m2 transfer, not on abort or m0 transfers.
REQ-027 At least one IDLE cycle SHALL separate consecutive transfers; i_wb_ack in IDLE SHALL be ignored.

Reset
REQ-028 On i_rst: state IDLE, counter 0, round-robin favouring m1, o_grant=3, all acks, o_timeout, o_wb_cyc, o_wb_we 0.
REQ-029 i_rst mid-transfer SHALL abort it with no ack to any master; slave cyc low the following cycle.

Verification
REQ-030 m1 write adr 0x100 dat 0xDEADBEEF sel 0xF; slave acks 2 cycles after o_wb_cyc -> slave sees exact values, o_m1_ack one pulse, o_grant=1 while busy.
REQ-031 m1 and m2 request continuously, slave acks next cycle -> grants alternate 1,2,1,2 with one IDLE cycle between.
REQ-032 m0, m1, m2 request simultaneously -> m0 served first, then m1, then m2.
REQ-033 TIMEOUT=4, m2 read, slave never acks -> o_m2_ack with rdt 0 and o_timeout on 4th BUSY cycle; FSM IDLE next cycle.
REQ-034 i_wb_ack coincident with timeout cycle, rdt 0x12345678 -> master receives 0x12345678, o_timeout stays 0.
REQ-035 i_rst asserted during BUSY, then m1 aborts by dropping cyc in a fresh transfer -> no ack either time, o_grant=3 after each.
